// File: rtl/fixed_point_dot_product_controller_if.sv
// Handshake and data bundle for the fixed-point dot-product controller.
// The slave side is the controller; the master side is the job/operand source.
interface fixed_point_dot_product_controller_if #(
   parameter int p_INPUT_WIDTH = 4,
   parameter int p_LEN_WIDTH   = 4
);
   localparam int ACC_W = 2 * p_INPUT_WIDTH + p_LEN_WIDTH;

   logic                     i_START;
   logic [p_LEN_WIDTH-1:0]   i_LENGTH;
   logic                     i_ABORT;
   logic [p_INPUT_WIDTH-1:0] i_A;
   logic [p_INPUT_WIDTH-1:0] i_B;
   logic                     i_VALID;
   logic                     o_READY;
   logic                     o_BUSY;
   logic [ACC_W-1:0]         o_RESULT;
   logic                     o_RESULT_VALID;
   logic                     i_RESULT_READY;

   modport slave (
      input  i_START, i_LENGTH, i_ABORT, i_A, i_B, i_VALID, i_RESULT_READY,
      output o_READY, o_BUSY, o_RESULT, o_RESULT_VALID
   );

   modport master (
      output i_START, i_LENGTH, i_ABORT, i_A, i_B, i_VALID, i_RESULT_READY,
      input  o_READY, o_BUSY, o_RESULT, o_RESULT_VALID
   );
endinterface

// File: rtl/fixed_point_dot_product_controller.sv
// Signed dot product of a streamed vector of operand pairs: a multiply stage
// feeding a wrapping accumulator, sequenced by an IDLE/RUN/DRAIN/DONE FSM.
module fixed_point_dot_product_controller #(
   parameter int p_INPUT_WIDTH = 4,
   parameter int p_LEN_WIDTH   = 4
) (
   input logic i_CLK,
   input logic i_RESET_N,
   fixed_point_dot_product_controller_if.slave bus
);
   localparam int PROD_W = 2 * p_INPUT_WIDTH;
   localparam int ACC_W  = 2 * p_INPUT_WIDTH + p_LEN_WIDTH;
   localparam logic [p_LEN_WIDTH-1:0] LenZero = {p_LEN_WIDTH{1'b0}};
   localparam logic [p_LEN_WIDTH-1:0] LenOne  = {{(p_LEN_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e                    state_q, state_d;
   logic [p_LEN_WIDTH-1:0]    count_q, count_d;
   logic [PROD_W-1:0]         prod_q, prod_d;
   logic                      prod_vld_q, prod_vld_d;
   logic [ACC_W-1:0]          acc_q, acc_d;
   logic                      handshake_s;
   logic signed [PROD_W-1:0]  a_ext_s, b_ext_s, mult_s;

   assign a_ext_s = {{p_INPUT_WIDTH{bus.i_A[p_INPUT_WIDTH-1]}}, bus.i_A};
   assign b_ext_s = {{p_INPUT_WIDTH{bus.i_B[p_INPUT_WIDTH-1]}}, bus.i_B};
   assign mult_s  = a_ext_s * b_ext_s;

   // An abort in the same cycle as a valid pair wins, so that pair never enters the pipeline.
   assign handshake_s = (state_q == S_RUN) & bus.i_VALID & ~bus.i_ABORT;

   assign bus.o_READY        = (state_q == S_RUN);
   assign bus.o_BUSY         = (state_q != S_IDLE);
   assign bus.o_RESULT_VALID = (state_q == S_DONE);
   assign bus.o_RESULT       = acc_q;

   // Next-state, pipeline and accumulator update.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      prod_d     = prod_q;
      prod_vld_d = 1'b0;
      if (prod_vld_q) begin
         acc_d = acc_q + {{p_LEN_WIDTH{prod_q[PROD_W-1]}}, prod_q};
      end else begin
         acc_d = acc_q;
      end

      case (state_q)
         S_IDLE: begin
            if (bus.i_START) begin
               count_d = bus.i_LENGTH;
               acc_d   = {ACC_W{1'b0}};
               state_d = (bus.i_LENGTH == LenZero) ? S_DONE : S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (bus.i_ABORT) begin
               state_d = S_IDLE;
            end else if (handshake_s) begin
               prod_d     = mult_s;
               prod_vld_d = 1'b1;
               count_d    = count_q - LenOne;
               state_d    = (count_q == LenOne) ? S_DRAIN : S_RUN;
            end else begin
               state_d = S_RUN;
            end
         end
         S_DRAIN: begin
            state_d = bus.i_ABORT ? S_IDLE : S_DONE;
         end
         S_DONE: begin
            if (bus.i_ABORT || bus.i_RESULT_READY) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, count, product and accumulator registers.
   always_ff @(posedge i_CLK or negedge i_RESET_N) begin
      if (!i_RESET_N) begin
         state_q    <= S_IDLE;
         count_q    <= {p_LEN_WIDTH{1'b0}};
         prod_q     <= {PROD_W{1'b0}};
         prod_vld_q <= 1'b0;
         acc_q      <= {ACC_W{1'b0}};
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         prod_q     <= prod_d;
         prod_vld_q <= prod_vld_d;
         acc_q      <= acc_d;
      end
   end
endmodule

// File: tb/tb_fixed_point_dot_product_controller.sv
// Directed bench for the dot-product controller: a job-level reference model
// checked every cycle, plus hand-computed result and latency expectations.
module tb_fixed_point_dot_product_controller;
   localparam int W     = 4;
   localparam int L     = 4;
   localparam int ACC_W = 2 * W + L;

   localparam int P_IDLE   = 0;
   localparam int P_ACCEPT = 1;
   localparam int P_FINISH = 2;
   localparam int P_RESULT = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   int m_phase    = P_IDLE;
   int m_sum      = 0;
   int m_left     = 0;
   int m_cyc      = 0;
   int m_hs_cycle = 0;
   int dut_hs     = 0;

   fixed_point_dot_product_controller_if #(.p_INPUT_WIDTH(W), .p_LEN_WIDTH(L)) bus ();

   fixed_point_dot_product_controller #(.p_INPUT_WIDTH(W), .p_LEN_WIDTH(L)) dut (
      .i_CLK     (clk),
      .i_RESET_N (rst_n),
      .bus       (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Job-level reference: sum of products of every accepted pair, result two cycles after the last one.
   initial forever begin
      int pa, pb;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_phase = P_IDLE;
         m_sum   = 0;
         m_left  = 0;
      end else begin
         if (bus.i_VALID && bus.o_READY) dut_hs++;
         case (m_phase)
            P_IDLE: begin
               if (bus.i_START) begin
                  m_sum   = 0;
                  m_left  = int'(bus.i_LENGTH);
                  m_phase = (m_left == 0) ? P_RESULT : P_ACCEPT;
               end
            end
            P_ACCEPT: begin
               if (bus.i_ABORT) begin
                  m_phase = P_IDLE;
               end else if (bus.i_VALID) begin
                  pa = $signed(bus.i_A);
                  pb = $signed(bus.i_B);
                  m_sum      = m_sum + pa * pb;
                  m_hs_cycle = m_cyc;
                  m_left     = m_left - 1;
                  if (m_left == 0) m_phase = P_FINISH;
               end
            end
            P_FINISH: m_phase = bus.i_ABORT ? P_IDLE : P_RESULT;
            P_RESULT: if (bus.i_ABORT || bus.i_RESULT_READY) m_phase = P_IDLE;
            default:  m_phase = P_IDLE;
         endcase
         m_cyc++;
      end
   end

   // Per-cycle comparison of DUT outputs against the model.
   initial forever begin
      logic [ACC_W-1:0] exp_res;
      @(negedge clk);
      if (rst_n) begin
         check("busy",  32'(bus.o_BUSY),         32'(m_phase != P_IDLE));
         check("ready", 32'(bus.o_READY),        32'(m_phase == P_ACCEPT));
         check("rvalid",32'(bus.o_RESULT_VALID), 32'(m_phase == P_RESULT));
         if (m_phase == P_RESULT) begin
            exp_res = m_sum[ACC_W-1:0];
            check("result_model", 32'(bus.o_RESULT), 32'(exp_res));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input int len);
      bus.i_START  = 1'b1;
      bus.i_LENGTH = len[L-1:0];
      step();
      bus.i_START  = 1'b0;
   endtask

   task automatic feed(input int a, input int b, input int gaps);
      bus.i_VALID = 1'b0;
      repeat (gaps) step();
      bus.i_A     = a[W-1:0];
      bus.i_B     = b[W-1:0];
      bus.i_VALID = 1'b1;
      step();
      bus.i_VALID = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      bit seen;
      seen = 1'b0;
      lat  = -1;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (bus.o_RESULT_VALID) begin
            seen = 1'b1;
            lat  = m_cyc - m_hs_cycle;
         end
      end
      if (!seen) check("result_valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic release_result();
      bus.i_RESULT_READY = 1'b1;
      step();
      bus.i_RESULT_READY = 1'b0;
      @(negedge clk);
      check("idle_after_ready", 32'(bus.o_BUSY), 32'd0);
   endtask

   initial begin
      int lat, hs0;
      bus.i_START = 1'b0; bus.i_LENGTH = '0; bus.i_ABORT = 1'b0;
      bus.i_A = '0; bus.i_B = '0; bus.i_VALID = 1'b0; bus.i_RESULT_READY = 1'b0;

      // Reset values without any clock edge.
      #1;
      check("rst_ready",  32'(bus.o_READY),        32'd0);
      check("rst_busy",   32'(bus.o_BUSY),         32'd0);
      check("rst_rvalid", 32'(bus.o_RESULT_VALID), 32'd0);
      check("rst_result", 32'(bus.o_RESULT),       32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Three pairs, no stalls: 6 - 20 - 7 = -21.
      start_job(3);
      feed(2, 3, 0);
      feed(-4, 5, 0);
      feed(7, -1, 0);
      wait_valid(lat);
      check("t1_latency", 32'(lat), 32'd2);
      check("t1_result",  32'(bus.o_RESULT), 32'h0000_0FEB);
      check("t1_model",   32'(m_sum), 32'hFFFF_FFEB);
      release_result();

      // Zero length goes straight to a zero result.
      start_job(0);
      @(negedge clk);
      check("t2_rvalid", 32'(bus.o_RESULT_VALID), 32'd1);
      check("t2_result", 32'(bus.o_RESULT), 32'd0);
      release_result();

      // Fifteen (-8,-8) pairs with random stalls: 15 * 64 = 960.
      start_job(15);
      hs0 = dut_hs;
      for (int i = 0; i < 15; i++) feed(-8, -8, int'($urandom_range(0, 2)));
      wait_valid(lat);
      check("t3_result",     32'(bus.o_RESULT), 32'h0000_03C0);
      check("t3_handshakes", 32'(dut_hs - hs0), 32'd15);
      check("t3_latency",    32'(lat), 32'd2);
      release_result();

      // Result held while the consumer stalls; START in DONE is ignored. 3 * -2 = -6.
      start_job(1);
      feed(3, -2, 0);
      wait_valid(lat);
      for (int i = 0; i < 5; i++) begin
         bus.i_START = (i == 2);
         bus.i_LENGTH = 4'd5;
         step();
         bus.i_START = 1'b0;
         @(negedge clk);
         check("t4_busy",   32'(bus.o_BUSY),   32'd1);
         check("t4_result", 32'(bus.o_RESULT), 32'h0000_0FFA);
      end
      release_result();

      // Abort on the third handshake, then a fresh single-pair job.
      start_job(4);
      feed(1, 2, 0);
      feed(1, 2, 0);
      bus.i_A = 4'd5; bus.i_B = 4'd5;
      bus.i_VALID = 1'b1; bus.i_ABORT = 1'b1;
      step();
      bus.i_VALID = 1'b0; bus.i_ABORT = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t5_no_result", 32'(bus.o_RESULT_VALID), 32'd0);
         check("t5_idle",      32'(bus.o_BUSY),         32'd0);
      end
      start_job(1);
      feed(1, 1, 0);
      wait_valid(lat);
      check("t5_result", 32'(bus.o_RESULT), 32'd1);
      release_result();

      // Asynchronous reset while draining.
      start_job(2);
      feed(3, 3, 0);
      feed(2, 2, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_ready",  32'(bus.o_READY),        32'd0);
      check("t6_busy",   32'(bus.o_BUSY),         32'd0);
      check("t6_rvalid", 32'(bus.o_RESULT_VALID), 32'd0);
      check("t6_result", 32'(bus.o_RESULT),       32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      start_job(1);
      feed(-1, -1, 0);
      wait_valid(lat);
      check("t6_new_result", 32'(bus.o_RESULT), 32'd1);
      release_result();

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fixed_point_dot_product_controller.md
FIXED_POINT_DOT_PRODUCT_CONTROLLER -- requirements
Module: fixed_point_dot_product_controller

Interface
REQ-001 Parameter p_INPUT_WIDTH, default 4: signed operand width.
REQ-002 Parameter p_LEN_WIDTH, default 4: vector-length field width; maximum length is 2^p_LEN_WIDTH-1.
REQ-003 Derived width ACC_W = 2*p_INPUT_WIDTH + p_LEN_WIDTH.
REQ-004 i_CLK  input  1: single clock; all state changes on its rising edge.
REQ-005 i_RESET_N  input  1: asynchronous, active-low reset.
REQ-006 i_START  input  1: job request; sampled only in IDLE.
REQ-007 i_LENGTH  input  p_LEN_WIDTH: unsigned pair count, latched with an accepted i_START.
REQ-008 i_ABORT  input  1: cancels the current job.
REQ-009 i_A, i_B  input  p_INPUT_WIDTH each, signed: operand pair.
REQ-010 i_VALID  input  1: operand pair is valid.
REQ-011 o_READY  output  1: block accepts a pair this cycle.
REQ-012 o_BUSY  output  1: high in every state except IDLE.
REQ-013 o_RESULT  output  ACC_W, signed: dot-product result.
REQ-014 o_RESULT_VALID  output  1: o_RESULT is valid.
REQ-015 i_RESULT_READY  input  1: consumer accepts the result.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-017 IDLE + i_START: on the next edge, latch the count = i_LENGTH, clear the accumulator and the product-valid flag, then go to RUN (length nonzero) or DONE (length zero).
REQ-018 i_START outside IDLE SHALL be ignored.
REQ-019 o_READY SHALL be 1 only in RUN; a handshake is i_VALID & o_READY in the same cycle.
REQ-020 Stage 1: on each handshake, the product register SHALL capture sign-extended i_A*i_B (2*p_INPUT_WIDTH bits) and set the product-valid flag; with no handshake, the flag clears.
REQ-021 Stage 2: each edge with product-valid set, the accumulator SHALL add the sign-extended product; addition wraps in two's complement, with no saturation.
REQ-022 Each handshake SHALL decrement the count; the handshake that takes the count to 0 moves RUN to DRAIN on the same edge.
REQ-023 DRAIN SHALL last exactly one cycle, absorbing the last product, then go to DONE.
REQ-024 Latency: o_RESULT_VALID SHALL rise 2 cycles after the cycle of the final handshake.
REQ-025 In DONE, o_RESULT_VALID=1, and o_RESULT SHALL hold stable until i_RESULT_READY=1; that edge returns the FSM to IDLE.
REQ-026 o_RESULT SHALL equal the accumulator register.
REQ-027 Outside DONE, o_RESULT_VALID SHALL be 0.
REQ-028 i_VALID gaps in RUN SHALL stall without corrupting the count or the accumulator.
REQ-029 i_ABORT in any non-IDLE state SHALL go to IDLE on the next edge and clear the product-valid flag; no result is issued.
REQ-030 i_ABORT has priority over a simultaneous handshake, and the discarded pair is not accumulated.
REQ-031 i_ABORT in IDLE has no effect.
REQ-032 i_ABORT in DONE has priority over i_RESULT_READY; the result is dropped.

Reset
REQ-033 While i_RESET_N=0, with no clock required, the block SHALL be in IDLE with o_READY=0, o_BUSY=0, o_RESULT_VALID=0 and o_RESULT=0.
REQ-034 Reset SHALL also clear the count, the product register and the product-valid flag.
REQ-035 Reset asserted mid-job SHALL discard the job entirely.
REQ-036 The first edge after deassertion SHALL be able to accept i_START.

Verification (p_INPUT_WIDTH=4, p_LEN_WIDTH=4, ACC_W=12)
REQ-037 Stimulus: LENGTH=3, pairs (2,3), (-4,5), (7,-1), no stalls. Response: o_RESULT=-21 (12'hFEB), o_RESULT_VALID 2 cycles after the last handshake.
REQ-038 Stimulus: LENGTH=0. Response: o_READY never asserts; o_RESULT=0 with o_RESULT_VALID in the cycle after the i_START edge.
REQ-039 Stimulus: LENGTH=15, all pairs (-8,-8), random i_VALID gaps. Response: o_RESULT=960 (12'h3C0), exactly 15 handshakes.
REQ-040 Stimulus: i_RESULT_READY held low for 5 cycles in DONE, with i_START pulsed. Response: o_RESULT stable, o_BUSY=1, i_START ignored; IDLE after the ready edge.
REQ-041 Stimulus: i_ABORT coincident with the 3rd handshake of LENGTH=4, then a new job LENGTH=1 with pair (1,1). Response: no o_RESULT_VALID for the aborted job; the new result is 1.
REQ-042 Stimulus: i_RESET_N driven low asynchronously during DRAIN. Response: all outputs reach their reset values before the next clock edge.
